// File: rtl/hba_arbiter.sv
// hba_arbiter: round-robin HBA bus arbiter with registered one-hot grant.
// Define HBA_ARB_TIMEOUT_EN to add the grant watchdog and per-master lockout mask.
module hba_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int OWNER_WIDTH    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic                   hba_clk,
    input  logic                   hba_resetn,
    input  logic [NUM_MASTERS-1:0] hba_mrequest,
    input  logic                   hba_xferack,
    output logic [NUM_MASTERS-1:0] hba_mgrant,
    output logic                   arb_busy,
    output logic [OWNER_WIDTH-1:0] arb_owner,
    output logic                   arb_timeout
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grant_q, req_m, mask_q;
    logic [OWNER_WIDTH-1:0] owner_q, last_q, pick_d;
    logic                   busy_q, found_d, owner_req, to_hit;

    assign owner_req = |(hba_mrequest & grant_q);
    assign req_m     = hba_mrequest & ~mask_q;

`ifdef HBA_ARB_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    logic                     timeout_q;
    assign to_hit = state_q == GRANTED && owner_req && !hba_xferack &&
                    cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    assign arb_timeout = timeout_q;
`else
    logic unused_xferack;
    assign unused_xferack = hba_xferack;
    assign mask_q         = '0;
    assign to_hit         = 1'b0;
    assign arb_timeout    = 1'b0;
`endif

    // Scan starts just past the last owner, so the previous owner ranks lowest.
    always_comb begin
        found_d = 1'b0;
        pick_d  = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!found_d && req_m[IW'((int'(last_q) + k) % NUM_MASTERS)]) begin
                found_d = 1'b1;
                pick_d  = OWNER_WIDTH'((int'(last_q) + k) % NUM_MASTERS);
            end
        end
    end

    always_ff @(posedge hba_clk or negedge hba_resetn) begin
        if (!hba_resetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            last_q    <= OWNER_WIDTH'(NUM_MASTERS - 1);
`ifdef HBA_ARB_TIMEOUT_EN
            mask_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_q <= NUM_MASTERS'(1) << pick_d;
                        owner_q <= pick_d;
                        last_q  <= pick_d;
                        busy_q  <= 1'b1;
                        state_q <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (!owner_req || to_hit) begin
                        grant_q <= '0;
                        owner_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef HBA_ARB_TIMEOUT_EN
            // A revoked master stays locked out until it is seen idle once.
            timeout_q <= to_hit;
            mask_q    <= (mask_q & hba_mrequest) | (to_hit ? grant_q : '0);
            cnt_q     <= (state_q != GRANTED || hba_xferack) ? '0 : cnt_q + 1'b1;
`endif
        end
    end

    assign hba_mgrant = grant_q;
    assign arb_busy   = busy_q;
    assign arb_owner  = owner_q;
endmodule

// File: tb/tb_hba_arbiter.sv
// tb_hba_arbiter: scoreboard bench for hba_arbiter; a cycle model queues the
// expected registered outputs per edge, popped and compared after the edge.
module tb_hba_arbiter;
    localparam int N  = 4;
    localparam int OW = 2;
    localparam int TO = 8;

    logic          hba_clk = 1'b0, hba_resetn = 1'b0, hba_xferack = 1'b0;
    logic [N-1:0]  hba_mrequest = '0;
    logic [N-1:0]  hba_mgrant;
    logic          arb_busy, arb_timeout;
    logic [OW-1:0] arb_owner;

    always #5 hba_clk = ~hba_clk;

    hba_arbiter #(.NUM_MASTERS(N), .OWNER_WIDTH(OW), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(16)) dut (
        .hba_clk(hba_clk), .hba_resetn(hba_resetn), .hba_mrequest(hba_mrequest),
        .hba_xferack(hba_xferack), .hba_mgrant(hba_mgrant), .arb_busy(arb_busy),
        .arb_owner(arb_owner), .arb_timeout(arb_timeout)
    );

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [N-1:0]  g;
        logic [OW-1:0] o;
        logic          b;
        logic          t;
    } exp_t;
    exp_t exp_q[$];

    int           m_state, m_last, m_owner, m_cnt;
    logic [N-1:0] m_grant, m_mask;
    logic         m_to;

    task model_reset();
        m_state = 0; m_last = N - 1; m_owner = 0; m_cnt = 0;
        m_grant = '0; m_mask = '0; m_to = 1'b0;
    endtask

    task model_step();
        logic [N-1:0] avail;
        int i, k, prev_owner;
        avail = hba_mrequest & ~m_mask;
        m_to  = 1'b0;
`ifdef HBA_ARB_TIMEOUT_EN
        m_mask = m_mask & hba_mrequest;
`endif
        if (m_state == 0) begin
            i = m_last;
            k = 0;
            do begin
                i = (i + 1) % N;
                k++;
            end while (!avail[i[1:0]] && k < N);
            if (avail[i[1:0]]) begin
                m_grant = '0;
                m_grant[i[1:0]] = 1'b1;
                m_owner = i; m_last = i; m_state = 1; m_cnt = 0;
            end
        end else if (m_state == 1) begin
            prev_owner = m_owner;
            if (!hba_mrequest[m_owner[1:0]]) begin
                m_grant = '0; m_owner = 0; m_state = 2;
            end
`ifdef HBA_ARB_TIMEOUT_EN
            else if (!hba_xferack && m_cnt == TO - 1) begin
                m_grant = '0; m_owner = 0; m_state = 2; m_to = 1'b1;
                m_mask[prev_owner[1:0]] = 1'b1;
            end else begin
                m_cnt = hba_xferack ? 0 : m_cnt + 1;
            end
`endif
        end else begin
            m_state = 0;
        end
    endtask

    task step(input string tag);
        exp_t e;
        model_step();
        exp_q.push_back('{g: m_grant, o: OW'(m_owner), b: (m_grant != 0), t: m_to});
        @(posedge hba_clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_grant"}, 32'(hba_mgrant), 32'(e.g));
        check({tag, "_owner"}, 32'(arb_owner), 32'(e.o));
        check({tag, "_busy"}, 32'(arb_busy), 32'(e.b));
        check({tag, "_timeout"}, 32'(arb_timeout), 32'(e.t));
    endtask

    task do_reset();
        hba_resetn = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        check("rst_grant", 32'(hba_mgrant), 0);
        check("rst_busy", 32'(arb_busy), 0);
        check("rst_owner", 32'(arb_owner), 0);
        check("rst_timeout", 32'(arb_timeout), 0);
        @(posedge hba_clk);
        #1;
        hba_resetn = 1'b1;
    endtask

    initial begin
        int order[$];
        int hold, gap, held, tos;
        logic [N-1:0] prev;

        // Directed 1: single request, then release dead cycle
        do_reset();
        hba_mrequest = 4'b0001;
        step("s1");
        check("s1_first_grant", 32'(hba_mgrant), 32'h1);
        check("s1_first_owner", 32'(arb_owner), 0);
        hba_mrequest = 4'b0000;
        step("s1d");
        check("s1_dead", 32'(hba_mgrant), 0);
        step("s1i");

        // Directed 2: all request, each owner drops after 3 cycles
        do_reset();
        hold = 0; gap = 0; prev = '0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            hba_mrequest = (hba_mgrant != 0 && hold >= 3) ? ~hba_mgrant : 4'hF;
            step("s2");
            if (hba_mgrant != 0) begin
                if (prev == 0) begin
                    order.push_back(int'(arb_owner));
                    if (order.size() > 1) check("s2_gap", 32'(gap), 2);
                end
                hold++;
                gap = 0;
            end else begin
                hold = 0;
                gap++;
            end
            prev = hba_mgrant;
        end
        check("s2_tenures", 32'(order.size()), 5);
        foreach (order[i]) check("s2_order", 32'(order[i]), 32'(i % N));

        // Directed 3: owner 2 drops while master 1 waits
        do_reset();
        hba_mrequest = 4'b0100;
        step("s3");
        check("s3_owner2", 32'(hba_mgrant), 32'h4);
        hba_mrequest = 4'b0110;
        step("s3h");
        step("s3h");
        check("s3_hold", 32'(hba_mgrant), 32'h4);
        hba_mrequest = 4'b0010;
        step("s3r");
        check("s3_release", 32'(hba_mgrant), 0);
        step("s3i");
        check("s3_idle", 32'(hba_mgrant), 0);
        step("s3n");
        check("s3_next", 32'(hba_mgrant), 32'h2);

        // Directed 4: async reset mid-tenure of master 3
        do_reset();
        hba_mrequest = 4'b1000;
        step("s4");
        check("s4_owner3", 32'(arb_owner), 3);
        step("s4h");
        #3;
        do_reset();
        hba_mrequest = 4'b1001;
        step("s4p");
        check("s4_prio0", 32'(hba_mgrant), 32'h1);

`ifdef HBA_ARB_TIMEOUT_EN
        // Watchdog revokes a silent master and locks it out
        do_reset();
        hba_mrequest = 4'b0010;
        hba_xferack = 1'b0;
        held = 0; tos = 0;
        for (int c = 0; c < 30; c++) begin
            step("s5");
            if (hba_mgrant != 0) held++;
            if (arb_timeout) tos++;
        end
        check("s5_held", 32'(held), TO);
        check("s5_pulses", 32'(tos), 1);
        hba_mrequest = 4'b0000;
        step("s5d");
        hba_mrequest = 4'b0010;
        step("s5r");
        check("s5_regrant", 32'(hba_mgrant), 32'h2);

        // Periodic xferack keeps the watchdog quiet
        do_reset();
        hba_mrequest = 4'b0010;
        tos = 0;
        for (int c = 0; c < 100; c++) begin
            hba_xferack = (c % 5 == 4);
            step("s6");
            if (arb_timeout) tos++;
        end
        hba_xferack = 1'b0;
        check("s6_no_timeout", 32'(tos), 0);
        check("s6_held", 32'(hba_mgrant), 32'h2);
`else
        // Without the watchdog a master may hold the bus indefinitely
        do_reset();
        hba_mrequest = 4'b0100;
        held = 0;
        for (int c = 0; c < 40; c++) begin
            step("s5n");
            if (hba_mgrant == 4'b0100) held++;
        end
        check("s5n_held", 32'(held), 40);
`endif

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            hba_mrequest = N'($urandom);
            hba_xferack = ($urandom_range(0, 3) == 0);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
